// File: rtl/cpu_defs.sv
// Shared definitions for the hardwired control sequencer: opcodes, IR field
// positions, step-state encoding and opcode class decode.
package cpu_defs;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_ROR  = 5'b01001;
    localparam logic [4:0] OP_ROL  = 5'b01010;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 27;
    localparam int RA_HI  = 26;
    localparam int RA_LO  = 23;
    localparam int RB_HI  = 22;
    localparam int RB_LO  = 19;
    localparam int RC_HI  = 18;
    localparam int RC_LO  = 15;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_T6   = 4'd7,
        ST_HALT = 4'd8
    } state_t;

    function automatic logic is_alu3(input logic [4:0] opc);
        logic r;
        case (opc)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: r = 1'b1;
            default:                        r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_muldiv(input logic [4:0] opc);
        logic r;
        case (opc)
            OP_MUL, OP_DIV: r = 1'b1;
            default:        r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_unary(input logic [4:0] opc);
        logic r;
        case (opc)
            OP_NEG, OP_NOT: r = 1'b1;
            default:        r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/reg_decoder_4_16.sv
// 4-bit register index to 16-bit one-hot select, forced to zero when disabled.
module reg_decoder_4_16 (
    input  logic [3:0]  idx,
    input  logic        en,
    output logic [15:0] onehot
);

    // One-hot expansion of the register index
    always_comb begin
        onehot = 16'h0000;
        if (en) begin
            onehot[idx] = 1'b1;
        end else begin
            onehot = 16'h0000;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired T0-T6 control FSM: fetches through the memory handshake, decodes
// IR and drives all datapath strobes, register selects and the ALU op code.
module control_sequencer
    import cpu_defs::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             run,
    input  logic [31:0]      ir,
    input  logic             mem_ready,
    output logic             mem_rd,
    output logic             pc_out,
    output logic             zlo_out,
    output logic             zhi_out,
    output logic             mdr_out,
    output logic             mar_in,
    output logic             pc_enable,
    output logic             pc_increment,
    output logic             mdr_enable,
    output logic             mdr_read,
    output logic             ir_enable,
    output logic             y_enable,
    output logic             zlo_enable,
    output logic             zhi_enable,
    output logic             lo_enable,
    output logic             hi_enable,
    output logic [15:0]      reg_in,
    output logic [15:0]      reg_out,
    output logic [4:0]       op_code,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    state_t           state_r;
    state_t           state_s;
    logic [4:0]       opc_s;
    logic [3:0]       ra_s;
    logic [3:0]       rb_s;
    logic [3:0]       rc_s;
    logic             alu3_s;
    logic             muldiv_s;
    logic             unary_s;
    logic             retire_s;
    logic             set_illegal_s;
    logic             rin_en_s;
    logic             rout_en_s;
    logic [3:0]       rin_idx_s;
    logic [3:0]       rout_idx_s;
    logic [CNT_W-1:0] instr_count_r;
    logic             illegal_r;
    logic             unused_ir_s;

    assign opc_s       = ir[OPC_HI:OPC_LO];
    assign ra_s        = ir[RA_HI:RA_LO];
    assign rb_s        = ir[RB_HI:RB_LO];
    assign rc_s        = ir[RC_HI:RC_LO];
    assign unused_ir_s = ^ir[RC_LO-1:0];
    assign alu3_s      = is_alu3(opc_s);
    assign muldiv_s    = is_muldiv(opc_s);
    assign unary_s     = is_unary(opc_s);
    assign instr_count = instr_count_r;
    assign illegal     = illegal_r;

    // Step-state register
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Retired-instruction counter and sticky illegal flag
    always_ff @(posedge clk) begin
        if (!clr) begin
            instr_count_r <= {CNT_W{1'b0}};
            illegal_r     <= 1'b0;
        end else begin
            if (retire_s) begin
                instr_count_r <= instr_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (set_illegal_s) begin
                illegal_r <= 1'b1;
            end
        end
    end

    // Next-state and Moore strobe decode
    always_comb begin
        state_s       = state_r;
        mem_rd        = 1'b0;
        pc_out        = 1'b0;
        zlo_out       = 1'b0;
        zhi_out       = 1'b0;
        mdr_out       = 1'b0;
        mar_in        = 1'b0;
        pc_enable     = 1'b0;
        pc_increment  = 1'b0;
        mdr_enable    = 1'b0;
        mdr_read      = 1'b0;
        ir_enable     = 1'b0;
        y_enable      = 1'b0;
        zlo_enable    = 1'b0;
        zhi_enable    = 1'b0;
        lo_enable     = 1'b0;
        hi_enable     = 1'b0;
        op_code       = 5'b00000;
        halted        = 1'b0;
        retire_s      = 1'b0;
        set_illegal_s = 1'b0;
        rin_en_s      = 1'b0;
        rout_en_s     = 1'b0;
        rin_idx_s     = 4'd0;
        rout_idx_s    = 4'd0;
        case (state_r)
            ST_IDLE: begin
                if (run) begin
                    state_s = ST_T0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_T0: begin
                pc_out       = 1'b1;
                mar_in       = 1'b1;
                pc_increment = 1'b1;
                state_s      = ST_T1;
            end
            ST_T1: begin
                mem_rd   = 1'b1;
                mdr_read = 1'b1;
                if (mem_ready) begin
                    mdr_enable = 1'b1;
                    state_s    = ST_T2;
                end else begin
                    state_s = ST_T1;
                end
            end
            ST_T2: begin
                mdr_out   = 1'b1;
                ir_enable = 1'b1;
                state_s   = ST_T3;
            end
            ST_T3: begin
                if (opc_s == OP_NOP) begin
                    retire_s = 1'b1;
                    state_s  = ST_IDLE;
                end else if (opc_s == OP_HALT) begin
                    retire_s = 1'b1;
                    state_s  = ST_HALT;
                end else if (alu3_s || unary_s || muldiv_s) begin
                    rout_en_s  = 1'b1;
                    rout_idx_s = muldiv_s ? ra_s : rb_s;
                    y_enable   = 1'b1;
                    state_s    = ST_T4;
                end else begin
                    set_illegal_s = 1'b1;
                    state_s       = ST_HALT;
                end
            end
            ST_T4: begin
                rout_en_s  = 1'b1;
                rout_idx_s = alu3_s ? rc_s : rb_s;
                op_code    = opc_s;
                zlo_enable = 1'b1;
                zhi_enable = muldiv_s;
                state_s    = ST_T5;
            end
            ST_T5: begin
                zlo_out = 1'b1;
                if (muldiv_s) begin
                    lo_enable = 1'b1;
                    state_s   = ST_T6;
                end else begin
                    rin_en_s  = 1'b1;
                    rin_idx_s = ra_s;
                    retire_s  = 1'b1;
                    state_s   = ST_IDLE;
                end
            end
            ST_T6: begin
                zhi_out   = 1'b1;
                hi_enable = 1'b1;
                retire_s  = 1'b1;
                state_s   = ST_IDLE;
            end
            ST_HALT: begin
                halted  = 1'b1;
                state_s = ST_HALT;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    reg_decoder_4_16 u_reg_in (
        .idx    (rin_idx_s),
        .en     (rin_en_s),
        .onehot (reg_in)
    );

    reg_decoder_4_16 u_reg_out (
        .idx    (rout_idx_s),
        .en     (rout_en_s),
        .onehot (reg_out)
    );

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: a directed vector table, handwritten
// reset/halt/illegal sequences and randomized instructions against a trace model.
module tb_control_sequencer;

    localparam int CNT_W = 4;

    localparam int B_MEM_RD  = 0;
    localparam int B_PC_OUT  = 1;
    localparam int B_ZLO_OUT = 2;
    localparam int B_ZHI_OUT = 3;
    localparam int B_MDR_OUT = 4;
    localparam int B_MAR_IN  = 5;
    localparam int B_PC_INC  = 7;
    localparam int B_MDR_EN  = 8;
    localparam int B_MDR_RD  = 9;
    localparam int B_IR_EN   = 10;
    localparam int B_Y_EN    = 11;
    localparam int B_ZLO_EN  = 12;
    localparam int B_ZHI_EN  = 13;
    localparam int B_LO_EN   = 14;
    localparam int B_HI_EN   = 15;

    typedef struct packed {
        logic [15:0]      strobes;
        logic [15:0]      reg_in;
        logic [15:0]      reg_out;
        logic [4:0]       op_code;
        logic             halted;
        logic             illegal;
        logic [CNT_W-1:0] cnt;
    } obs_t;

    typedef struct {
        logic [31:0]      ir;
        int               waits;
        logic [CNT_W-1:0] exp_cnt;
        logic             exp_halt;
    } vec_t;

    logic clk = 1'b0;
    logic clr, run, mem_ready;
    logic [31:0] ir;
    logic mem_rd, pc_out, zlo_out, zhi_out, mdr_out, mar_in, pc_enable, pc_increment;
    logic mdr_enable, mdr_read, ir_enable, y_enable, zlo_enable, zhi_enable, lo_enable, hi_enable;
    logic [15:0] reg_in, reg_out;
    logic [4:0] op_code;
    logic halted, illegal;
    logic [CNT_W-1:0] instr_count;

    int checks = 0;
    int errors = 0;
    logic [CNT_W-1:0] m_cnt;
    logic m_halted, m_illegal;
    obs_t act;

    always #5 clk = ~clk;

    control_sequencer #(.CNT_W(CNT_W)) dut (
        .clk(clk), .clr(clr), .run(run), .ir(ir), .mem_ready(mem_ready),
        .mem_rd(mem_rd), .pc_out(pc_out), .zlo_out(zlo_out), .zhi_out(zhi_out),
        .mdr_out(mdr_out), .mar_in(mar_in), .pc_enable(pc_enable),
        .pc_increment(pc_increment), .mdr_enable(mdr_enable), .mdr_read(mdr_read),
        .ir_enable(ir_enable), .y_enable(y_enable), .zlo_enable(zlo_enable),
        .zhi_enable(zhi_enable), .lo_enable(lo_enable), .hi_enable(hi_enable),
        .reg_in(reg_in), .reg_out(reg_out), .op_code(op_code), .halted(halted),
        .illegal(illegal), .instr_count(instr_count)
    );

    assign act = {hi_enable, lo_enable, zhi_enable, zlo_enable, y_enable, ir_enable,
                  mdr_read, mdr_enable, pc_increment, pc_enable, mar_in, mdr_out,
                  zhi_out, zlo_out, pc_out, mem_rd,
                  reg_in, reg_out, op_code, halted, illegal, instr_count};

    // 0 illegal, 1 three-register ALU, 2 mul/div, 3 unary, 4 nop, 5 halt
    function automatic int op_class(input logic [4:0] op);
        case (op)
            5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10: return 1;
            5'd14, 5'd15: return 2;
            5'd16, 5'd17: return 3;
            5'd26:        return 4;
            5'd27:        return 5;
            default:      return 0;
        endcase
    endfunction

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] a,
                                       input logic [3:0] b, input logic [3:0] c);
        return {op, a, b, c, 15'h0000};
    endfunction

    function automatic obs_t quiet();
        obs_t o;
        o         = '0;
        o.halted  = m_halted;
        o.illegal = m_illegal;
        o.cnt     = m_cnt;
        return o;
    endfunction

    task automatic check_cycle(input obs_t e, input string name);
        int bus;
        @(negedge clk);
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, e);
        end
        bus = $countones({pc_out, zlo_out, zhi_out, mdr_out, reg_out});
        checks++;
        if (bus > 1) begin
            errors++;
            $display("FAIL %s bus_drivers: got %0d, expected at most 1", name, bus);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_cnt     = '0;
        m_halted  = 1'b0;
        m_illegal = 1'b0;
    endtask

    task automatic do_reset();
        clr = 1'b0;
        run = 1'b0;
        @(posedge clk);
        #1;
        clr = 1'b1;
        model_reset();
        check_cycle(quiet(), "reset_idle");
    endtask

    task automatic check_halt();
        obs_t e;
        run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            e = quiet();
            check_cycle(e, "halt_hold");
        end
    endtask

    // Expected cycle-by-cycle trace of one instruction, starting in IDLE
    task automatic run_instr(input logic [31:0] instr, input int waits,
                             input bit clr_t4, input bit drop_run);
        obs_t e;
        int cls;
        logic [4:0] op;
        logic [3:0] a, b, c;
        op  = instr[31:27];
        a   = instr[26:23];
        b   = instr[22:19];
        c   = instr[18:15];
        cls = op_class(op);
        ir  = $urandom;
        if (!run) check_cycle(quiet(), "idle_wait");
        run       = 1'b1;
        mem_ready = 1'($urandom_range(0, 1));
        check_cycle(quiet(), "idle");
        if (drop_run) run = 1'b0;
        e = quiet();
        e.strobes[B_PC_OUT] = 1'b1;
        e.strobes[B_MAR_IN] = 1'b1;
        e.strobes[B_PC_INC] = 1'b1;
        check_cycle(e, "t0");
        for (int i = 0; i < waits; i++) begin
            mem_ready = 1'b0;
            e = quiet();
            e.strobes[B_MEM_RD] = 1'b1;
            e.strobes[B_MDR_RD] = 1'b1;
            check_cycle(e, "t1_wait");
        end
        mem_ready = 1'b1;
        e = quiet();
        e.strobes[B_MEM_RD] = 1'b1;
        e.strobes[B_MDR_RD] = 1'b1;
        e.strobes[B_MDR_EN] = 1'b1;
        check_cycle(e, "t1_ready");
        mem_ready = 1'($urandom_range(0, 1));
        e = quiet();
        e.strobes[B_MDR_OUT] = 1'b1;
        e.strobes[B_IR_EN]   = 1'b1;
        check_cycle(e, "t2");
        ir = instr;
        e  = quiet();
        if (cls == 4) begin
            check_cycle(e, "t3_nop");
            m_cnt++;
            return;
        end
        if (cls == 5) begin
            check_cycle(e, "t3_halt");
            m_cnt++;
            m_halted = 1'b1;
            return;
        end
        if (cls == 0) begin
            check_cycle(e, "t3_illegal");
            m_illegal = 1'b1;
            m_halted  = 1'b1;
            return;
        end
        e.reg_out = 16'h0001 << ((cls == 2) ? a : b);
        e.strobes[B_Y_EN] = 1'b1;
        check_cycle(e, "t3");
        e = quiet();
        e.reg_out = 16'h0001 << ((cls == 1) ? c : b);
        e.op_code = op;
        e.strobes[B_ZLO_EN] = 1'b1;
        e.strobes[B_ZHI_EN] = (cls == 2);
        if (clr_t4) clr = 1'b0;
        check_cycle(e, "t4");
        if (clr_t4) begin
            clr = 1'b1;
            run = 1'b0;
            model_reset();
            check_cycle(quiet(), "clr_t4_idle");
            return;
        end
        e = quiet();
        e.strobes[B_ZLO_OUT] = 1'b1;
        if (cls == 2) begin
            e.strobes[B_LO_EN] = 1'b1;
            check_cycle(e, "t5_muldiv");
            e = quiet();
            e.strobes[B_ZHI_OUT] = 1'b1;
            e.strobes[B_HI_EN]   = 1'b1;
            check_cycle(e, "t6");
        end else begin
            e.reg_in = 16'h0001 << a;
            check_cycle(e, "t5");
        end
        m_cnt++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[18];
        logic [4:0] legal_ops[13];
        logic [4:0] op;

        vecs[0]  = '{mk(5'b00011, 4'd1, 4'd2, 4'd3), 0, 4'd1, 1'b0};
        vecs[1]  = '{mk(5'b00011, 4'd1, 4'd2, 4'd3), 3, 4'd2, 1'b0};
        vecs[2]  = '{mk(5'b01110, 4'd6, 4'd7, 4'd0), 0, 4'd3, 1'b0};
        vecs[3]  = '{mk(5'b01111, 4'd5, 4'd9, 4'd0), 1, 4'd4, 1'b0};
        vecs[4]  = '{mk(5'b10000, 4'd4, 4'd10, 4'd0), 0, 4'd5, 1'b0};
        vecs[5]  = '{mk(5'b10001, 4'd15, 4'd0, 4'd0), 2, 4'd6, 1'b0};
        vecs[6]  = '{mk(5'b11010, 4'd0, 4'd0, 4'd0), 0, 4'd7, 1'b0};
        vecs[7]  = '{mk(5'b00100, 4'd0, 4'd15, 4'd7), 0, 4'd8, 1'b0};
        vecs[8]  = '{mk(5'b00111, 4'd3, 4'd3, 4'd3), 0, 4'd9, 1'b0};
        vecs[9]  = '{mk(5'b01000, 4'd8, 4'd1, 4'd14), 0, 4'd10, 1'b0};
        vecs[10] = '{mk(5'b01001, 4'd12, 4'd13, 4'd2), 1, 4'd11, 1'b0};
        vecs[11] = '{mk(5'b01010, 4'd9, 4'd4, 4'd6), 0, 4'd12, 1'b0};
        vecs[12] = '{mk(5'b00101, 4'd2, 4'd5, 4'd11), 0, 4'd13, 1'b0};
        vecs[13] = '{mk(5'b00110, 4'd14, 4'd7, 4'd1), 0, 4'd14, 1'b0};
        vecs[14] = '{mk(5'b11010, 4'd3, 4'd3, 4'd3), 1, 4'd15, 1'b0};
        vecs[15] = '{mk(5'b11010, 4'd0, 4'd0, 4'd0), 0, 4'd0, 1'b0};
        vecs[16] = '{mk(5'b00011, 4'd1, 4'd2, 4'd3), 0, 4'd1, 1'b0};
        vecs[17] = '{mk(5'b11011, 4'd0, 4'd0, 4'd0), 0, 4'd2, 1'b1};

        legal_ops = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
                      5'd14, 5'd15, 5'd16, 5'd17, 5'd26};

        clr = 1'b0; run = 1'b0; mem_ready = 1'b0; ir = 32'h0000_0000;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b1;
        check_cycle(quiet(), "reset_idle");

        for (int i = 0; i < 18; i++) begin
            run_instr(vecs[i].ir, vecs[i].waits, 1'b0, 1'b0);
            checks++;
            if (instr_count !== vecs[i].exp_cnt || halted !== vecs[i].exp_halt) begin
                errors++;
                $display("FAIL vec%0d: got count=%0d halted=%0b, expected count=%0d halted=%0b",
                         i, instr_count, halted, vecs[i].exp_cnt, vecs[i].exp_halt);
            end
        end
        check_halt();
        do_reset();

        run_instr(mk(5'b00011, 4'd1, 4'd2, 4'd3), 0, 1'b0, 1'b0);
        run_instr(mk(5'b11111, 4'd1, 4'd2, 4'd3), 0, 1'b0, 1'b0);
        checks++;
        if (instr_count !== 4'd1 || illegal !== 1'b1 || halted !== 1'b1) begin
            errors++;
            $display("FAIL illegal_op: got count=%0d illegal=%0b halted=%0b, expected 1 1 1",
                     instr_count, illegal, halted);
        end
        check_halt();
        do_reset();

        run_instr(mk(5'b00011, 4'd1, 4'd2, 4'd3), 1, 1'b0, 1'b0);
        run_instr(mk(5'b00011, 4'd1, 4'd2, 4'd3), 0, 1'b1, 1'b0);
        run_instr(mk(5'b00011, 4'd1, 4'd2, 4'd3), 0, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            op = legal_ops[$urandom_range(0, 12)];
            run_instr(mk(op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                         4'($urandom_range(0, 15))),
                      $urandom_range(0, 3), 1'b0, ($urandom_range(0, 3) == 0));
        end

        do op = 5'($urandom_range(0, 31)); while (op_class(op) != 0);
        run_instr(mk(op, 4'd2, 4'd4, 4'd6), $urandom_range(0, 2), 1'b0, 1'b0);
        check_halt();
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control FSM that sits directly upstream of the datapath. It fetches each instruction through the memory handshake, decodes the opcode held in IR and drives every datapath control strobe, one-hot register select and ALU `op_code` for the T0–T6 step sequence. It covers reg-reg ALU ops, unary ops, mul/div into HI/LO, nop and halt.

## Interface
Parameters:
- `CNT_W`, 16: width of the retired-instruction counter.

Ports:
- `clk` in 1: sole clock, rising edge.
- `clr` in 1: reset, synchronous, active-low.
- `run` in 1: fetch permission. Sampled only in IDLE.
- `ir` in 32: datapath IR contents.
- `mem_ready` in 1: memory read data valid on datapath `data_in`.
- `mem_rd` out 1: memory read request.
- `pc_out`, `zlo_out`, `zhi_out`, `mdr_out` out 1 each: bus drive strobes.
- `mar_in`, `pc_enable`, `pc_increment`, `mdr_enable`, `mdr_read`, `ir_enable`, `y_enable`, `zlo_enable`, `zhi_enable`, `lo_enable`, `hi_enable` out 1 each: register load strobes.
- `reg_in` out 16: one-hot GPR load enable.
- `reg_out` out 16: one-hot GPR bus drive.
- `op_code` out 5: ALU operation select.
- `halted` out 1: HALT executed.
- `illegal` out 1: undefined opcode seen. Sticky.
- `instr_count` out CNT_W: number of retired instructions.

## Operation
- IR fields:
  - opcode = ir[31:27]
  - ra = ir[26:23]
  - rb = ir[22:19]
  - rc = ir[18:15]
- Opcode classes:
  - 3-reg ALU: add 00011, sub 00100, and 00101, or 00110, shr 00111, shl 01000, ror 01001, rol 01010
  - mul 01110, div 01111
  - unary: neg 10000, not 10001
  - nop 11010
  - halt 11011
  - All other values are illegal.
- States and per-state outputs (all outputs are 0 unless listed):
  - IDLE: no strobes. Moves to T0 when `run`=1.
  - T0: `pc_out`, `mar_in`, `pc_increment`.
  - T1: `mem_rd`, `mdr_read`. `mdr_enable` is asserted only while `mem_ready`=1. Stays in T1 until `mem_ready`.
  - T2: `mdr_out`, `ir_enable`.
  - T3: decodes the opcode.
    - nop: retires and goes to IDLE.
    - halt: retires and goes to HALT.
    - illegal: sets `illegal`, goes to HALT, and does not count.
    - All other opcodes: `reg_out`=onehot(rb) for 3-reg and unary, onehot(ra) for mul/div; `y_enable`.
  - T4:
    - 3-reg: `reg_out`=onehot(rc).
    - mul/div: onehot(rb).
    - unary: onehot(rb).
    - All of them: `op_code`=opcode, `zlo_enable`, and `zhi_enable` for mul/div only.
  - T5:
    - 3-reg and unary: `zlo_out`, `reg_in`=onehot(ra), retire, go to IDLE.
    - mul/div: `zlo_out`, `lo_enable`.
  - T6: mul/div only. `zhi_out`, `hi_enable`, retire, go to IDLE.
  - HALT: no strobes, `halted`=1. Terminal until `clr`.
- Retire means `instr_count` += 1, modulo 2^CNT_W. 0xFFFF wraps to 0.
- At most one bus-drive strobe is active in any cycle (`pc_out`, `zlo_out`, `zhi_out`, `mdr_out`, or any `reg_out` bit).

## Timing
- All control outputs are Moore, decoded from the state register and `ir`. They are valid for the whole state and captured by the datapath at the closing edge.
- `ir` is used only from T3 onward; it is stable by then because it was loaded at the end of T2.
- Instruction latency from T0 with `mem_ready` held high:
  - 3-reg or unary: 6 cycles
  - mul/div: 7 cycles
  - nop or halt: 4 cycles
  - Each cycle with `mem_ready`=0 in T1 adds one cycle.
- Every instruction returns through IDLE, which costs one cycle. Back-to-back throughput is therefore latency+1.
- `mem_ready` outside T1 is ignored.
- Reset: `clr`=0 at a rising edge forces the following, overriding everything else including mid-instruction and mid-wait:
  - state = IDLE
  - all strobes = 0
  - `reg_in`/`reg_out` = 0
  - `op_code` = 0
  - `halted` = 0
  - `illegal` = 0
  - `instr_count` = 0
- If `run` drops mid-instruction, the current instruction still completes. The sequencer then waits in IDLE.

## Structure
- Package `cpu_defs`:
  - opcode localparams
  - state encoding (IDLE, T0–T6, HALT)
  - IR field bit positions
  - the `is_alu3` / `is_muldiv` / `is_unary` class decode functions
- Sub-module `reg_decoder_4_16` (4-bit index → 16-bit one-hot with enable), instantiated twice: once for `reg_in`, once for `reg_out`.

## Test plan
- Reset, then one idle cycle with `run`=0: all outputs 0 and `instr_count`=0. Raising `run` gives T0 with `pc_out`=`mar_in`=`pc_increment`=1.
- add r1,r2,r3 (ir=0x1891_8000), `mem_ready` held high:
  - T3 `reg_out`=0x0004
  - T4 `reg_out`=0x0008, `op_code`=00011
  - T5 `reg_in`=0x0002
  - `instr_count`=1 after 6 cycles from T0.
- Same fetch with `mem_ready` low for 3 cycles: `mem_rd` stays high for 4 cycles and `mdr_enable` pulses only in the last of them.
- mul r6,r7 (ir=0x7338_0000):
  - T4 `zlo_enable`=`zhi_enable`=1
  - T5 `lo_enable`
  - T6 `hi_enable`
  - No `reg_in` bit is ever set.
- Opcode 11111: `illegal`=1 and `halted`=1, `instr_count` unchanged, no strobes asserted thereafter despite `run`=1.
- `clr`=0 pulse while in T4 of an add: the next cycle shows IDLE with all outputs 0 and the counter cleared. After `clr` returns high, a fresh fetch starts at T0 once `run` is high.
